// File: rtl/window_gen.sv
// KxK sliding window builder fed one column per cycle from a line buffer.
// Define WINDOW_GEN_STRIDE2_EN to emit only every other window in each axis.
module window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL     = 5,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                                      wg_clk,
  input  logic                                      wg_rst_b,
  input  logic                                      wg_en,
  input  logic [KERNEL-1:0][DATA_WIDTH-1:0]         wg_taps_i,
  output logic [KERNEL*KERNEL-1:0][DATA_WIDTH-1:0]  wg_win_o,
  output logic                                      wg_valid_o,
  output logic                                      wg_frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KK = KERNEL * KERNEL;

  localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          last_col;
  logic          last_row;
  logic          in_win;
  logic          stride_ok;

  logic [KK-1:0][DATA_WIDTH-1:0] win_d;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign in_win   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

`ifdef WINDOW_GEN_STRIDE2_EN
  // Even offset from K-1 means same LSB as K-1.
  localparam logic KP = 1'((KERNEL - 1) % 2);
  assign stride_ok = (row_q[0] == KP) && (col_q[0] == KP);
`else
  assign stride_ok = 1'b1;
`endif

  // Shift every row left one column; newest column enters at K-1.
  always_comb begin
    win_d = wg_win_o;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        if (c < KERNEL - 1)
          win_d[r*KERNEL+c] = wg_win_o[r*KERNEL+c+1];
        else
          win_d[r*KERNEL+c] = wg_taps_i[KERNEL-1-r];
      end
    end
  end

  always_ff @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      wg_win_o        <= '0;
      wg_valid_o      <= 1'b0;
      wg_frame_done_o <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
    end else begin
      wg_valid_o      <= 1'b0;
      wg_frame_done_o <= 1'b0;
      if (wg_en) begin
        wg_win_o        <= win_d;
        wg_valid_o      <= in_win && stride_ok;
        wg_frame_done_o <= last_col && last_row;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen with a pixel-index reference model.
// Honors WINDOW_GEN_STRIDE2_EN for expected valid counts.
module tb_window_gen;

  localparam int DW   = 32;
  localparam int K    = 5;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NPIX = W * H;
`ifdef WINDOW_GEN_STRIDE2_EN
  localparam int FRAME_V = 196;
`else
  localparam int FRAME_V = 784;
`endif

  logic                     wg_clk = 1'b0;
  logic                     wg_rst_b = 1'b0;
  logic                     wg_en = 1'b0;
  logic [K-1:0][DW-1:0]     wg_taps_i = '0;
  logic [K*K-1:0][DW-1:0]   wg_win_o;
  logic                     wg_valid_o;
  logic                     wg_frame_done_o;

  window_gen #(
    .DATA_WIDTH(DW), .KERNEL(K), .IMG_W(W), .IMG_H(H)
  ) dut (
    .wg_clk(wg_clk),
    .wg_rst_b(wg_rst_b),
    .wg_en(wg_en),
    .wg_taps_i(wg_taps_i),
    .wg_win_o(wg_win_o),
    .wg_valid_o(wg_valid_o),
    .wg_frame_done_o(wg_frame_done_o)
  );

  always #5 wg_clk = ~wg_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Pixel value at (row, col) relative to the image, as the line buffer delivers it.
  function automatic logic [DW-1:0] pix(int row, int col);
    return DW'(row * W + col);
  endfunction

  function automatic logic want_valid(int n);
    int r, c;
    logic ok;
    r  = n / W;
    c  = n % W;
    ok = (r >= K - 1) && (c >= K - 1);
`ifdef WINDOW_GEN_STRIDE2_EN
    ok = ok && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
    return ok;
  endfunction

  // Reference model: linear index of accepted pixels.
  int   n_acc;
  int   last_acc;
  logic m_valid, m_done, m_held;

  always @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      n_acc    <= 0;
      last_acc <= -1;
      m_valid  <= 1'b0;
      m_done   <= 1'b0;
      m_held   <= 1'b0;
    end else if (wg_en) begin
      m_valid  <= want_valid(n_acc);
      m_done   <= (n_acc == NPIX - 1);
      last_acc <= n_acc;
      n_acc    <= (n_acc + 1) % NPIX;
      m_held   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_held  <= 1'b1;
    end
  end

  int   vcount, dcount, badcol, gapv, first_n;
  logic got_first;
  logic [DW-1:0] first_w0, first_w24, w12;
  logic [K*K-1:0][DW-1:0] prev_win;

  always @(negedge wg_clk) begin
    if (!wg_rst_b) begin
      chk("rst_valid", 64'(wg_valid_o), 64'd0);
      chk("rst_done", 64'(wg_frame_done_o), 64'd0);
      for (int i = 0; i < K*K; i++) chk("rst_win", 64'(wg_win_o[i]), 64'd0);
    end else begin
      chk("valid", 64'(wg_valid_o), 64'(m_valid));
      chk("frame_done", 64'(wg_frame_done_o), 64'(m_done));
      if (m_valid) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            chk("win", 64'(wg_win_o[r*K+c]),
                64'(pix(last_acc / W - (K-1-r), last_acc % W - (K-1-c))));
      end
      if (m_held) begin
        for (int i = 0; i < K*K; i++) chk("win_hold", 64'(wg_win_o[i]), 64'(prev_win[i]));
      end
      if (wg_valid_o) begin
        vcount++;
        if (!got_first) begin
          got_first = 1'b1;
          first_n   = last_acc;
          first_w0  = wg_win_o[0];
          first_w24 = wg_win_o[24];
        end
        if (last_acc % W < K - 1) badcol++;
        if (last_acc == 10*W + 20) w12 = wg_win_o[12];
        if (m_held) gapv++;
      end
      if (wg_frame_done_o) dcount++;
    end
    prev_win = wg_win_o;
  end

  task automatic drive_pix(int n);
    @(negedge wg_clk);
    wg_en = 1'b1;
    for (int i = 0; i < K; i++) wg_taps_i[i] = DW'((n / W - i) * W + n % W);
  endtask

  task automatic idle(int cycles);
    repeat (cycles) begin
      @(negedge wg_clk);
      wg_en = 1'b0;
    end
  endtask

  task automatic run_frame(bit gap);
    for (int n = 0; n < NPIX; n++) begin
      if (gap && n == 10*W + 5) idle(5);
      drive_pix(n);
    end
  endtask

  task automatic clear_stats();
    vcount = 0; dcount = 0; badcol = 0; gapv = 0;
    first_n = -1; got_first = 1'b0;
    first_w0 = '1; first_w24 = '1; w12 = '1;
  endtask

  initial begin
    clear_stats();
    idle(3);
    #1;
    chk("reset_valid", 64'(wg_valid_o), 64'd0);
    chk("reset_win24", 64'(wg_win_o[24]), 64'd0);
    @(negedge wg_clk);
    wg_rst_b = 1'b1;
    idle(2);
    #1;
    clear_stats();

    // Single frame
    run_frame(1'b0);
    idle(3);
    #1;
    chk("f1_valid_count", 64'(vcount), 64'(FRAME_V));
    chk("f1_done_count", 64'(dcount), 64'd1);
    chk("f1_first_pixel", 64'(first_n), 64'(4*W + 4));
    chk("f1_first_w0", 64'(first_w0), 64'h00);
    chk("f1_first_w24", 64'(first_w24), 64'h84);
    chk("f1_w12_at_10_20", 64'(w12), 64'h112);
    chk("f1_wrap_cols", 64'(badcol), 64'd0);

    // Two back-to-back frames, the first with an enable gap in row 10
    clear_stats();
    run_frame(1'b1);
    run_frame(1'b0);
    idle(3);
    #1;
    chk("f23_valid_count", 64'(vcount), 64'(2*FRAME_V));
    chk("f23_done_count", 64'(dcount), 64'd2);
    chk("f23_gap_valid", 64'(gapv), 64'd0);
    chk("f23_wrap_cols", 64'(badcol), 64'd0);

    // Asynchronous reset mid-frame at pixel (15,7)
    clear_stats();
    for (int n = 0; n <= 15*W + 7; n++) drive_pix(n);
    idle(1);
    #1;
    chk("pre_rst_w24", 64'(wg_win_o[24]), 64'h1E7);
    #1;
    wg_rst_b = 1'b0;
    #1;
    chk("async_rst_valid", 64'(wg_valid_o), 64'd0);
    chk("async_rst_done", 64'(wg_frame_done_o), 64'd0);
    chk("async_rst_w24", 64'(wg_win_o[24]), 64'd0);
    idle(3);
    wg_rst_b = 1'b1;
    idle(1);
    #1;
    clear_stats();
    run_frame(1'b0);
    idle(3);
    #1;
    chk("post_rst_valid_count", 64'(vcount), 64'(FRAME_V));
    chk("post_rst_first_pixel", 64'(first_n), 64'(4*W + 4));
    chk("post_rst_done_count", 64'(dcount), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
